// File: rtl/serial_tx_pkg.sv
// Shared types and width helpers for the serial transmit scheduler.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int frame_len(input int n_req, input int word_w);
    return id_width(n_req) + word_w;
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Source-side handshake and serial-line signals of the transmit scheduler.
interface serial_tx_scheduler_if
  import serial_tx_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 4
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*WORD_W-1:0] data;
  logic                    en;
  logic                    ser_out;
  logic                    ser_valid;
  logic                    frame_start;
  logic [N_REQ-1:0]        ack;
  logic                    busy;
  logic [ID_W-1:0]         cur_id;

  modport master (
    output req, data, en,
    input  ser_out, ser_valid, frame_start, ack, busy, cur_id
  );

  modport slave (
    input  req, data, en,
    output ser_out, ser_valid, frame_start, ack, busy, cur_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import serial_tx_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any_req
);
  int            cand;
  logic [ID_W-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx      = '0;
    any_req  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = ID_W'(cand);
      if (req[cand_idx]) begin
        idx     = cand_idx;
        any_req = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = any_req && (idx == ID_W'(gi));
    end
  endgenerate
endmodule

// File: rtl/serial_tx_scheduler.sv
// Grants one source at a time and shifts out its id then data word, MSB first,
// acking the source once the whole frame has left. All outputs are registered.
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 4
) (
  input logic                  clk,
  input logic                  clr,
  serial_tx_scheduler_if.slave bus
);
  localparam int ID_W      = id_width(N_REQ);
  localparam int FRAME_LEN = frame_len(N_REQ, WORD_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  state_t               state_reg, state_next;
  logic [FRAME_LEN-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [ID_W-1:0]      ptr_reg, ptr_next;
  logic [ID_W-1:0]      cur_id_reg, cur_id_next;
  logic [N_REQ-1:0]     gnt_mask_reg, gnt_mask_next;
  logic [N_REQ-1:0]     ack_reg, ack_next;
  logic                 ser_out_reg, ser_out_next;
  logic                 ser_valid_reg, ser_valid_next;
  logic                 frame_start_reg, frame_start_next;
  logic                 busy_reg, busy_next;

  logic [N_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [WORD_W-1:0]    words [N_REQ];
  logic [FRAME_LEN-1:0] frame_cur;
  logic [CNT_W-1:0]     cnt_cur;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_reg),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
      assign words[gi] = bus.data[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // The GRANT edge builds the frame from the live word, so bit 0 can leave on that same edge;
  // en at an edge decides whether the following cycle carries a bit.
  assign frame_cur = (state_reg == GRANT) ? {cur_id_reg, words[cur_id_reg]} : shift_reg;
  assign cnt_cur   = (state_reg == GRANT) ? '0 : cnt_reg;

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    cnt_next         = cnt_reg;
    ptr_next         = ptr_reg;
    cur_id_next      = cur_id_reg;
    gnt_mask_next    = gnt_mask_reg;
    ack_next         = '0;
    ser_out_next     = ser_out_reg;
    ser_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    busy_next        = busy_reg;
    case (state_reg)
      IDLE: begin
        ser_out_next = 1'b0;
        if (arb_any) begin
          state_next    = GRANT;
          cur_id_next   = arb_idx;
          gnt_mask_next = arb_gnt;
          busy_next     = 1'b1;
        end
      end
      GRANT, SEND: begin
        if (state_reg == GRANT)
          ptr_next = (cur_id_reg == ID_W'(N_REQ - 1)) ? '0 : cur_id_reg + 1'b1;
        state_next = SEND;
        shift_next = frame_cur;
        cnt_next   = cnt_cur;
        if (cnt_cur == CNT_W'(FRAME_LEN)) begin
          state_next   = DONE;
          ser_out_next = 1'b0;
          ack_next     = gnt_mask_reg;
        end else if (bus.en) begin
          ser_out_next     = frame_cur[FRAME_LEN-1];
          ser_valid_next   = 1'b1;
          frame_start_next = (cnt_cur == '0);
          shift_next       = {frame_cur[FRAME_LEN-2:0], 1'b0};
          cnt_next         = cnt_cur + 1'b1;
        end
      end
      DONE: begin
        state_next   = IDLE;
        busy_next    = 1'b0;
        ser_out_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      cnt_reg         <= '0;
      ptr_reg         <= '0;
      cur_id_reg      <= '0;
      gnt_mask_reg    <= '0;
      ack_reg         <= '0;
      ser_out_reg     <= 1'b0;
      ser_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      cnt_reg         <= cnt_next;
      ptr_reg         <= ptr_next;
      cur_id_reg      <= cur_id_next;
      gnt_mask_reg    <= gnt_mask_next;
      ack_reg         <= ack_next;
      ser_out_reg     <= ser_out_next;
      ser_valid_reg   <= ser_valid_next;
      frame_start_reg <= frame_start_next;
      busy_reg        <= busy_next;
    end
  end

  assign bus.ser_out     = ser_out_reg;
  assign bus.ser_valid   = ser_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.ack         = ack_reg;
  assign bus.busy        = busy_reg;
  assign bus.cur_id      = cur_id_reg;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: frame-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_serial_tx_scheduler;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;
  localparam int FL  = IDW + W;

  logic clk = 1'b0;
  logic clr;
  serial_tx_scheduler_if #(.N_REQ(N), .WORD_W(W)) bus ();
  serial_tx_scheduler #(.N_REQ(N), .WORD_W(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;
  bit chk_on = 1'b0;

  // Reference model: stage 0 waiting, 1 granted, 2 sending, 3 acking.
  int   m_stage = 0, m_ptr = 0, m_id = 0, m_sent = 0;
  int   m_q[$];
  logic e_ser_out = 1'b0, e_valid = 1'b0, e_fs = 1'b0, e_busy = 1'b0;
  logic [N-1:0]   e_ack = '0;
  logic [IDW-1:0] e_id  = '0;

  int cap_bits[$], cap_cyc[$], fs_cyc[$], ack_val[$], ack_cyc[$];
  int busy_first = -1, busy_last = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int frame_val(input int f);
    int v = 0;
    for (int b = 0; b < FL; b++) v = (v << 1) | (qat(cap_bits, f*FL + b) & 1);
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit go_emit;
    int word;
    go_emit = 1'b0;
    cyc++;
    e_fs  = 1'b0;
    e_ack = '0;
    if (clr === 1'b1) begin
      m_stage = 0; m_ptr = 0; m_q.delete();
      e_ser_out = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_id = '0;
    end else begin
      if (m_stage == 3) begin
        m_stage = 0; e_busy = 1'b0; e_valid = 1'b0; e_ser_out = 1'b0;
      end else if (m_stage == 1) begin
        m_ptr = (m_id + 1) % N;
        word  = (int'(bus.data) >> (m_id * W)) & ((1 << W) - 1);
        m_q.delete();
        for (int b = IDW - 1; b >= 0; b--) m_q.push_back((m_id >> b) & 1);
        for (int b = W - 1; b >= 0; b--)   m_q.push_back((word >> b) & 1);
        m_sent  = 0;
        m_stage = 2;
        go_emit = 1'b1;
      end else if (m_stage == 2) begin
        go_emit = 1'b1;
      end else begin
        e_valid = 1'b0; e_ser_out = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
          int c;
          c = (m_ptr + k) % N;
          if (((int'(bus.req) >> c) & 1) == 1) begin
            m_id = c; m_stage = 1;
          end
        end
        if (m_stage == 1) begin
          e_busy = 1'b1; e_id = IDW'(m_id);
        end
      end
      if (go_emit) begin
        if (m_q.size() == 0) begin
          m_stage = 3; e_ack = N'(1 << m_id); e_valid = 1'b0; e_ser_out = 1'b0;
        end else if (bus.en === 1'b1) begin
          e_ser_out = m_q.pop_front() != 0;
          e_valid   = 1'b1;
          e_fs      = (m_sent == 0);
          m_sent++;
        end else begin
          e_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int rel;
    if (chk_on) begin
      rel = cyc - t0;
      chk("ser_valid", 32'(bus.ser_valid), 32'(e_valid));
      chk("ser_out", 32'(bus.ser_out), 32'(e_ser_out));
      chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
      chk("ack", 32'(bus.ack), 32'(e_ack));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      if (e_busy) chk("cur_id", 32'(bus.cur_id), 32'(e_id));
      if (bus.ser_valid === 1'b1) begin
        cap_bits.push_back(int'(bus.ser_out));
        cap_cyc.push_back(rel);
      end
      if (bus.frame_start === 1'b1) fs_cyc.push_back(rel);
      if (bus.busy === 1'b1) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (bus.ack !== '0) begin
        ack_val.push_back(int'(bus.ack));
        ack_cyc.push_back(rel);
        $display("txn: ack=%b id=%0d rel_cycle=%0d", bus.ack, bus.cur_id, rel);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_cap();
    cap_bits.delete(); cap_cyc.delete(); fs_cyc.delete();
    ack_val.delete(); ack_cyc.delete();
    busy_first = -1; busy_last = -1;
    t0 = cyc;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int limit, input string name);
    int k = 0;
    while (ack_val.size() < n && k < limit) begin
      step();
      k++;
    end
    if (ack_val.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: acks %0d required %0d", name, ack_val.size(), n);
    end
  endtask

  task automatic wait_bits(input int n, input int limit, input string name);
    int k = 0;
    while (cap_bits.size() < n && k < limit) begin
      step();
      k++;
    end
    if (cap_bits.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: bits %0d required %0d", name, cap_bits.size(), n);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int exp_order[5];
    logic [N-1:0] rq, ack_now, m;
    exp_order = '{0, 1, 2, 3, 0};
    clr = 1'b1; bus.req = '0; bus.data = '0; bus.en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    #1;
    chk("rst_ser_valid", 32'(bus.ser_valid), 0);
    chk("rst_ser_out", 32'(bus.ser_out), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cur_id", 32'(bus.cur_id), 0);
    clr = 1'b0;
    step();

    // Single request from source 2 with word 1011
    start_cap();
    bus.data = 16'($urandom());
    bus.data[11:8] = 4'b1011;
    bus.req = 4'b0100;
    wait_acks(1, 20, "t1");
    bus.req = '0;
    step(); step();
    chk("t1_bits", 32'(frame_val(0)), 32'b101011);
    chk("t1_first_bit_cyc", 32'(qat(cap_cyc, 0)), 2);
    chk("t1_last_bit_cyc", 32'(qat(cap_cyc, 5)), 7);
    chk("t1_frame_start_cyc", 32'(qat(fs_cyc, 0)), 2);
    chk("t1_ack_cyc", 32'(qat(ack_cyc, 0)), 8);
    chk("t1_ack_val", 32'(qat(ack_val, 0)), 32'b0100);
    chk("t1_busy_first", 32'(busy_first), 1);
    chk("t1_busy_last", 32'(busy_last), 8);

    // All four requesting from a fresh pointer
    pulse_clr();
    start_cap();
    bus.data = 16'($urandom());
    bus.req = 4'b1111;
    wait_acks(5, 60, "t2");
    bus.req = '0;
    step(); step();
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("t2_ack%0d", f), 32'(qat(ack_val, f)), 32'(1 << exp_order[f]));
      chk($sformatf("t2_id%0d", f), 32'(frame_val(f) >> W), 32'(exp_order[f]));
    end

    // Three stalled cycles after the second bit
    start_cap();
    bus.req = 4'b0001;
    wait_bits(2, 20, "t3");
    bus.en = 1'b0;
    step(); step(); step();
    bus.en = 1'b1;
    wait_acks(1, 30, "t3");
    bus.req = '0;
    step(); step();
    chk("t3_third_bit_cyc", 32'(qat(cap_cyc, 2)), 7);
    chk("t3_ack_cyc", 32'(qat(ack_cyc, 0)), 11);
    chk("t3_nbits", 32'(cap_bits.size()), 6);

    // Reset in the middle of a frame with the request still held
    start_cap();
    bus.req = 4'b0010;
    wait_bits(4, 20, "t4");
    clr = 1'b1;
    step();
    chk("t4_clr_valid", 32'(bus.ser_valid), 0);
    chk("t4_clr_out", 32'(bus.ser_out), 0);
    chk("t4_clr_busy", 32'(bus.busy), 0);
    chk("t4_clr_ack", 32'(bus.ack), 0);
    clr = 1'b0;
    step();
    chk("t4_regrant_busy", 32'(bus.busy), 1);
    chk("t4_regrant_id", 32'(bus.cur_id), 1);
    wait_acks(1, 30, "t4");
    bus.req = '0;
    step(); step();
    chk("t4_ack_count", 32'(ack_val.size()), 1);
    chk("t4_ack_cyc", 32'(qat(ack_cyc, 0)), 14);

    // Source 3 arrives while source 0 keeps requesting
    pulse_clr();
    start_cap();
    bus.req = 4'b0001;
    wait_bits(2, 20, "t5");
    bus.req = 4'b1001;
    wait_acks(2, 30, "t5");
    bus.req = 4'b0001;
    wait_acks(3, 30, "t5");
    bus.req = '0;
    step(); step();
    chk("t5_ack0", 32'(qat(ack_val, 0)), 32'b0001);
    chk("t5_ack1", 32'(qat(ack_val, 1)), 32'b1000);
    chk("t5_ack2", 32'(qat(ack_val, 2)), 32'b0001);

    // Word changes after grant must not reach the line
    start_cap();
    bus.data = 16'($urandom());
    bus.data[15:12] = 4'b0110;
    bus.req = 4'b1000;
    wait_bits(1, 20, "t6");
    bus.data = 16'($urandom());
    bus.data[15:12] = 4'b1001;
    wait_acks(1, 20, "t6");
    bus.req = '0;
    step(); step();
    chk("t6_bits", 32'(frame_val(0)), 32'b110110);

    // Randomized traffic with stalls and one mid-run reset
    for (int k = 0; k < 600; k++) begin
      ack_now = bus.ack;
      rq = bus.req;
      for (int i = 0; i < N; i++) begin
        m = N'(1 << i);
        if ((ack_now & m) != '0) begin
          if ($urandom_range(0, 1) == 0) rq = rq & ~m;
        end else if ((rq & m) == '0 && $urandom_range(0, 5) == 0) begin
          rq = rq | m;
        end
      end
      bus.req  = rq;
      bus.data = 16'($urandom());
      bus.en   = ($urandom_range(0, 3) != 0);
      clr      = (k == 300);
      step();
    end
    clr = 1'b0;
    bus.req = '0;
    bus.en = 1'b1;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
